hw_sensor_responder: RTL and testbench
======================================

HW_SENSOR_RESPONDER -- requirements
Module: hw_sensor_responder

Interface
REQ-001 SHALL have parameter P_NO_CH_VOLT, default 9: number of voltage channels, 1..16.
REQ-002 SHALL have parameter P_NO_CH_TEMP, default 5: number of temperature channels, 1..16.
REQ-003 SHALL have parameter P_RSP_LATENCY, default 4: cycles from command end-of-packet to response header, 1..255.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-006 SHALL have ports command_ready_o (out, 1), command_valid_i (in, 1), command_data_i (in, 32), command_startofpacket_i (in, 1), command_endofpacket_i (in, 1): Avalon-ST command sink.
REQ-007 SHALL have ports response_ready_i (in, 1), response_valid_o (out, 1), response_data_o (out, 32), response_startofpacket_o (out, 1), response_endofpacket_o (out, 1): Avalon-ST response source.
REQ-008 SHALL have port voltage_sample_i, input, P_NO_CH_VOLT x 32: live voltage value per channel.
REQ-009 SHALL have port temperature_sample_i, input, P_NO_CH_TEMP x 32: live temperature value per channel.

Function
REQ-010 SHALL treat a beat as transferred only when valid and ready are both high, on both interfaces.
REQ-011 SHALL decode command word 0 (sop) as follows: opcode [7:0]; 0x18 = GET_VOLTAGE, 0x19 = GET_TEMPERATURE. SHALL decode word 1 (eop) as follows: channel mask [15:0].
REQ-012 SHALL implement states IDLE, CMD_ARG, DRAIN, WAIT, RSP_HDR, RSP_DATA.
REQ-013 SHALL drive command_ready_o high only in IDLE, CMD_ARG and DRAIN.
REQ-014 IDLE: SHALL discard a beat without sop. A sop beat with eop SHALL go to WAIT with error 3. A sop beat without eop SHALL latch the opcode and go to CMD_ARG.
REQ-015 CMD_ARG: a beat with eop SHALL latch the mask and go to WAIT. A beat without eop SHALL go to DRAIN with error 3. A beat with sop SHALL restart decode as in IDLE.
REQ-016 DRAIN: SHALL consume beats until an eop beat, then go to WAIT.
REQ-017 On every eop transfer, SHALL snapshot both sample arrays and load the latency counter with P_RSP_LATENCY.
REQ-018 WAIT: SHALL decrement the counter once per cycle and enter RSP_HDR so that response_valid_o first rises exactly P_RSP_LATENCY cycles after the eop transfer cycle.
REQ-019 SHALL determine the error code [3:0] by priority: 3 = malformed packet; 1 = unknown opcode; 2 = a mask bit set at index >= the channel count for that opcode; 0 = OK.
REQ-020 SHALL form the response header as: opcode echo [7:0], data-word count [12:8], error [19:16], zeros elsewhere. The count SHALL be the popcount of the mask when error = 0, and 0 otherwise.
REQ-021 RSP_HDR: SHALL assert sop on the header beat, and assert eop on it as well when count = 0.
REQ-022 RSP_DATA: SHALL send one snapshot word per set mask bit, in ascending channel order, with eop on the last word.
REQ-023 SHALL hold response_valid_o, response_data_o, response_startofpacket_o and response_endofpacket_o stable while response_ready_i is low.
REQ-024 SHALL return to IDLE in the cycle after the eop response transfer; a mask of 0 with a valid opcode SHALL give a header-only response with error 0.
REQ-025 SHALL not accept a new command before its response completes (no overlap).

Reset
REQ-026 While reset is low at a clock edge: state SHALL be IDLE, command_ready_o 0, response_valid_o 0, response_data_o 0, sop 0, eop 0, counter 0, snapshots 0, latched opcode/mask/error 0.
REQ-027 Reset asserted mid-command or mid-response SHALL abort the packet; no further response beats SHALL be emitted for it, and command_ready_o SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-028 With macro HW_SENSOR_RESPONDER_FAULT_INJ_EN defined, SHALL add input fault_inject_i (1 bit); fault_inject_i high on the eop transfer SHALL bitwise-invert the first data word of that response (the header is unaffected).
REQ-029 Without HW_SENSOR_RESPONDER_FAULT_INJ_EN, the port and its logic SHALL be absent and data words SHALL equal the snapshots.

Verification
REQ-030 GET_VOLTAGE, mask 0x0005, voltage[0]=0x00010000, voltage[2]=0x0000C000, ready always 1 -> header 0x00000218 at eop+4 cycles, then 0x00010000, then 0x0000C000 with eop.
REQ-031 Opcode 0x55, mask 0x0001 -> single-beat response 0x00010055 with sop=eop=1.
REQ-032 GET_TEMPERATURE, mask 0x0020 with P_NO_CH_TEMP=5 -> header 0x00020019, header only.
REQ-033 GET_TEMPERATURE, mask 0x001F, response_ready_i toggling 1/0 each cycle -> 5 data words in channel order, each held stable during ready=0.
REQ-034 Three-beat command (extra beat before eop) -> DRAIN consumes all beats; header 0x00030018, header only; a following valid command is answered normally.
REQ-035 Reset low during the 2nd data word -> valid drops the next cycle, ready=1 after release; new GET_VOLTAGE mask 0x0001 gives a complete, correct response.

Source files
------------

// File: rtl/hw_sensor_responder.sv
// rtl/hw_sensor_responder.sv - Avalon-ST voltage/temperature sensor command responder
// HW_SENSOR_RESPONDER_FAULT_INJ_EN adds fault_inject_i, which inverts the first data word of a response.
module hw_sensor_responder #(
  parameter int P_NO_CH_VOLT  = 9,
  parameter int P_NO_CH_TEMP  = 5,
  parameter int P_RSP_LATENCY = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic                          command_ready_o,
  input  logic                          command_valid_i,
  input  logic [31:0]                   command_data_i,
  input  logic                          command_startofpacket_i,
  input  logic                          command_endofpacket_i,
  input  logic                          response_ready_i,
  output logic                          response_valid_o,
  output logic [31:0]                   response_data_o,
  output logic                          response_startofpacket_o,
  output logic                          response_endofpacket_o,
`ifdef HW_SENSOR_RESPONDER_FAULT_INJ_EN
  input  logic                          fault_inject_i,
`endif
  input  logic [P_NO_CH_VOLT-1:0][31:0] voltage_sample_i,
  input  logic [P_NO_CH_TEMP-1:0][31:0] temperature_sample_i
);

  localparam logic [7:0] OP_VOLT       = 8'h18;
  localparam logic [7:0] OP_TEMP       = 8'h19;
  localparam logic [3:0] ERR_OK        = 4'd0;
  localparam logic [3:0] ERR_OPCODE    = 4'd1;
  localparam logic [3:0] ERR_RANGE     = 4'd2;
  localparam logic [3:0] ERR_MALFORMED = 4'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD_ARG, S_DRAIN, S_WAIT, S_RSP_HDR, S_RSP_DATA
  } state_t;

  // A one-cycle latency has no room for WAIT: the header follows the eop edge directly.
  localparam state_t S_AFTER_EOP = (P_RSP_LATENCY == 1) ? S_RSP_HDR : S_WAIT;

  function automatic logic [3:0] arg_error(input logic [7:0] op, input logic [15:0] m);
    logic over_v;
    logic over_t;
    over_v = 1'b0;
    over_t = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i >= P_NO_CH_VOLT && m[i]) over_v = 1'b1;
      if (i >= P_NO_CH_TEMP && m[i]) over_t = 1'b1;
    end
    if (op == OP_VOLT) return over_v ? ERR_RANGE : ERR_OK;
    if (op == OP_TEMP) return over_t ? ERR_RANGE : ERR_OK;
    return ERR_OPCODE;
  endfunction

  function automatic logic [4:0] popcount(input logic [15:0] m);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + {4'b0000, m[i]};
    return c;
  endfunction

  state_t                          state_q, state_d;
  logic [7:0]                      opcode_q, opcode_d;
  logic [15:0]                     mask_q, mask_d;
  logic [15:0]                     rem_q, rem_d;
  logic [3:0]                      err_q, err_d;
  logic [4:0]                      count_q, count_d;
  logic [7:0]                      cnt_q, cnt_d;
  logic [P_NO_CH_VOLT-1:0][31:0]   vsnap_q, vsnap_d;
  logic [P_NO_CH_TEMP-1:0][31:0]   tsnap_q, tsnap_d;

  logic        cmd_xfer, rsp_xfer, eop_xfer, restart, last_word;
  logic [7:0]  cmd_opcode;
  logic [15:0] cmd_mask;
  logic [3:0]  arg_err;
  logic [3:0]  data_idx;
  logic [31:0] data_word;
  logic [31:0] inv_mask;
  logic        unused_cmd_bits;

  assign cmd_opcode      = command_data_i[7:0];
  assign cmd_mask        = command_data_i[15:0];
  assign unused_cmd_bits = ^command_data_i[31:16];
  assign arg_err         = arg_error(opcode_q, cmd_mask);

  assign command_ready_o = reset &&
                           (state_q == S_IDLE || state_q == S_CMD_ARG || state_q == S_DRAIN);
  assign cmd_xfer  = command_valid_i && command_ready_o;
  assign eop_xfer  = cmd_xfer && command_endofpacket_i;
  assign restart   = cmd_xfer && command_startofpacket_i &&
                     (state_q == S_IDLE || state_q == S_CMD_ARG);
  assign rsp_xfer  = response_valid_o && response_ready_i;
  assign last_word = (rem_q & (rem_q - 16'd1)) == 16'd0;

`ifdef HW_SENSOR_RESPONDER_FAULT_INJ_EN
  logic fi_q, fi_d, first_q, first_d;
  assign inv_mask = {32{fi_q & first_q}};
`else
  assign inv_mask = '0;
`endif

  // Remaining-mask bits are retired low to high, so the lowest set bit is the current channel.
  always_comb begin
    data_idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (rem_q[i]) data_idx = 4'(i);
    end
    data_word = '0;
    for (int i = 0; i < P_NO_CH_VOLT; i++) begin
      if (opcode_q == OP_VOLT && data_idx == 4'(i)) data_word = vsnap_q[i];
    end
    for (int i = 0; i < P_NO_CH_TEMP; i++) begin
      if (opcode_q == OP_TEMP && data_idx == 4'(i)) data_word = tsnap_q[i];
    end
  end

  assign response_valid_o         = (state_q == S_RSP_HDR) || (state_q == S_RSP_DATA);
  assign response_startofpacket_o = (state_q == S_RSP_HDR);
  assign response_endofpacket_o   = ((state_q == S_RSP_HDR) && (count_q == 5'd0)) ||
                                    ((state_q == S_RSP_DATA) && last_word);

  always_comb begin
    response_data_o = '0;
    if (state_q == S_RSP_HDR) begin
      response_data_o = {12'h000, err_q, 3'b000, count_q, opcode_q};
    end else if (state_q == S_RSP_DATA) begin
      response_data_o = data_word ^ inv_mask;
    end
  end

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    mask_d   = mask_q;
    rem_d    = rem_q;
    err_d    = err_q;
    count_d  = count_q;
    cnt_d    = cnt_q;
    vsnap_d  = vsnap_q;
    tsnap_d  = tsnap_q;
`ifdef HW_SENSOR_RESPONDER_FAULT_INJ_EN
    fi_d     = fi_q;
    first_d  = first_q;
`endif
    if (eop_xfer) begin
      vsnap_d = voltage_sample_i;
      tsnap_d = temperature_sample_i;
      cnt_d   = 8'(P_RSP_LATENCY);
`ifdef HW_SENSOR_RESPONDER_FAULT_INJ_EN
      fi_d    = fault_inject_i;
`endif
    end
    if (restart) begin
      opcode_d = cmd_opcode;
      mask_d   = '0;
      count_d  = '0;
      if (command_endofpacket_i) begin
        err_d   = ERR_MALFORMED;
        state_d = S_AFTER_EOP;
      end else begin
        err_d   = ERR_OK;
        state_d = S_CMD_ARG;
      end
    end else begin
      case (state_q)
        S_CMD_ARG: begin
          if (cmd_xfer) begin
            if (command_endofpacket_i) begin
              mask_d  = cmd_mask;
              err_d   = arg_err;
              count_d = (arg_err == ERR_OK) ? popcount(cmd_mask) : 5'd0;
              state_d = S_AFTER_EOP;
            end else begin
              err_d   = ERR_MALFORMED;
              state_d = S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (eop_xfer) state_d = S_AFTER_EOP;
        end
        S_WAIT: begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q <= 8'd2) state_d = S_RSP_HDR;
        end
        S_RSP_HDR: begin
          if (rsp_xfer) begin
            if (count_q == 5'd0) begin
              state_d = S_IDLE;
            end else begin
              rem_d   = mask_q;
              state_d = S_RSP_DATA;
`ifdef HW_SENSOR_RESPONDER_FAULT_INJ_EN
              first_d = 1'b1;
`endif
            end
          end
        end
        S_RSP_DATA: begin
          if (rsp_xfer) begin
            rem_d = rem_q & (rem_q - 16'd1);
`ifdef HW_SENSOR_RESPONDER_FAULT_INJ_EN
            first_d = 1'b0;
`endif
            if (last_word) state_d = S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      opcode_q <= '0;
      mask_q   <= '0;
      rem_q    <= '0;
      err_q    <= '0;
      count_q  <= '0;
      cnt_q    <= '0;
      vsnap_q  <= '0;
      tsnap_q  <= '0;
`ifdef HW_SENSOR_RESPONDER_FAULT_INJ_EN
      fi_q     <= 1'b0;
      first_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      mask_q   <= mask_d;
      rem_q    <= rem_d;
      err_q    <= err_d;
      count_q  <= count_d;
      cnt_q    <= cnt_d;
      vsnap_q  <= vsnap_d;
      tsnap_q  <= tsnap_d;
`ifdef HW_SENSOR_RESPONDER_FAULT_INJ_EN
      fi_q     <= fi_d;
      first_q  <= first_d;
`endif
    end
  end

endmodule

// File: tb/tb_hw_sensor_responder.sv
// tb/tb_hw_sensor_responder.sv - randomized self-checking bench for hw_sensor_responder
module tb_hw_sensor_responder;

  localparam int NV  = 9;
  localparam int NT  = 5;
  localparam int LAT = 4;
  localparam logic [7:0] OP_V = 8'h18;
  localparam logic [7:0] OP_T = 8'h19;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                command_ready_o;
  logic                command_valid_i = 1'b0;
  logic [31:0]         command_data_i = '0;
  logic                command_startofpacket_i = 1'b0;
  logic                command_endofpacket_i = 1'b0;
  logic                response_ready_i = 1'b0;
  logic                response_valid_o;
  logic [31:0]         response_data_o;
  logic                response_startofpacket_o;
  logic                response_endofpacket_o;
  logic [NV-1:0][31:0] voltage_sample_i = '0;
  logic [NT-1:0][31:0] temperature_sample_i = '0;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  always #5 clk = ~clk;

  hw_sensor_responder #(
    .P_NO_CH_VOLT  (NV),
    .P_NO_CH_TEMP  (NT),
    .P_RSP_LATENCY (LAT)
  ) u_dut (
    .clk                      (clk),
    .reset                    (reset),
    .command_ready_o          (command_ready_o),
    .command_valid_i          (command_valid_i),
    .command_data_i           (command_data_i),
    .command_startofpacket_i  (command_startofpacket_i),
    .command_endofpacket_i    (command_endofpacket_i),
    .response_ready_i         (response_ready_i),
    .response_valid_o         (response_valid_o),
    .response_data_o          (response_data_o),
    .response_startofpacket_o (response_startofpacket_o),
    .response_endofpacket_o   (response_endofpacket_o),
`ifdef HW_SENSOR_RESPONDER_FAULT_INJ_EN
    .fault_inject_i           (1'b0),
`endif
    .voltage_sample_i         (voltage_sample_i),
    .temperature_sample_i     (temperature_sample_i)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shuffle_samples();
    for (int i = 0; i < NV; i++) voltage_sample_i[i] = $urandom();
    for (int i = 0; i < NT; i++) temperature_sample_i[i] = $urandom();
  endtask

  // Reference: header word then one snapshot per set mask bit, lowest channel first.
  task automatic build_expected(input logic [7:0] op, input logic [15:0] mask, input bit malformed,
                                input logic [NV-1:0][31:0] vs, input logic [NT-1:0][31:0] ts);
    int nch, err, cnt;
    exp_q.delete();
    nch = (op == OP_V) ? NV : NT;
    if (malformed) err = 3;
    else if (op != OP_V && op != OP_T) err = 1;
    else if ((32'(mask) >> nch) != 0) err = 2;
    else err = 0;
    cnt = 0;
    if (err == 0) for (int i = 0; i < 16; i++) if (mask[i]) cnt++;
    exp_q.push_back(32'(op) | (32'(cnt) << 8) | (32'(err) << 16));
    if (err == 0) begin
      for (int i = 0; i < 16; i++) begin
        if (mask[i]) exp_q.push_back((op == OP_V) ? vs[i] : ts[i]);
      end
    end
  endtask

  // kind: 0 normal, 1 single sop+eop beat, 2 extra beats before eop, 3 junk beats then normal
  task automatic run_txn(input string tag, input int kind, input logic [7:0] op,
                         input logic [15:0] mask, input int rmode, input bit keep,
                         input int abort_at);
    logic [33:0]         beats[$];
    logic [NV-1:0][31:0] vs;
    logic [NT-1:0][31:0] ts;
    logic [31:0]         w, pdata;
    logic                psop, peop;
    int                  n, waitc, lat, idx, nx;
    bit                  done, held, leak, aborted, stuck, rr, vleak;
    if (!keep) shuffle_samples();
    if (kind == 3) begin
      beats.push_back({2'b00, 32'($urandom())});
      beats.push_back({2'b01, 32'($urandom())});
    end
    w = $urandom();
    w[7:0] = op;
    if (kind == 1) begin
      beats.push_back({2'b11, w});
    end else begin
      beats.push_back({2'b10, w});
      if (kind == 2) begin
        nx = $urandom_range(3, 1);
        for (int i = 0; i < nx; i++) beats.push_back({2'b00, 32'($urandom())});
      end
      w = $urandom();
      w[15:0] = mask;
      beats.push_back({2'b01, w});
    end
    stuck = 1'b0;
    vs = voltage_sample_i;
    ts = temperature_sample_i;
    foreach (beats[b]) begin
      if ($urandom_range(3) == 0) begin
        command_valid_i = 1'b0;
        tick();
      end
      command_valid_i = 1'b1;
      {command_startofpacket_i, command_endofpacket_i, command_data_i} = beats[b];
      waitc = 0;
      while (!command_ready_o && waitc < 20) begin
        tick();
        waitc++;
      end
      if (waitc >= 20) stuck = 1'b1;
      vs = voltage_sample_i;
      ts = temperature_sample_i;
      tick();
    end
    command_valid_i = 1'b0;
    command_startofpacket_i = 1'b0;
    command_endofpacket_i = 1'b0;
    check_eq({tag, "_cmd_accept"}, 32'(stuck), 32'd0);
    shuffle_samples();
    build_expected(op, mask, (kind == 1 || kind == 2), vs, ts);

    got_q.delete();
    n = 1; lat = -1; idx = 0;
    done = 1'b0; held = 1'b0; leak = 1'b0; aborted = 1'b0;
    pdata = '0; psop = 1'b0; peop = 1'b0;
    while (!done && n < 300) begin
      if (command_ready_o) leak = 1'b1;
      if (response_valid_o && lat < 0) lat = n;
      if (held) begin
        check_eq({tag, "_hold_valid"}, 32'(response_valid_o), 32'd1);
        check_eq({tag, "_hold_data"}, response_data_o, pdata);
        check_eq({tag, "_hold_sop"}, 32'(response_startofpacket_o), 32'(psop));
        check_eq({tag, "_hold_eop"}, 32'(response_endofpacket_o), 32'(peop));
      end
      if (abort_at >= 0 && response_valid_o && idx == abort_at) begin
        aborted = 1'b1;
        break;
      end
      case (rmode)
        0:       rr = 1'b1;
        1:       rr = (n % 2) == 0;
        default: rr = 1'($urandom_range(1));
      endcase
      response_ready_i = rr;
      if (response_valid_o && rr) begin
        got_q.push_back(response_data_o);
        if (idx < exp_q.size()) check_eq({tag, "_word"}, response_data_o, exp_q[idx]);
        check_eq({tag, "_sop"}, 32'(response_startofpacket_o), 32'(idx == 0));
        check_eq({tag, "_eop"}, 32'(response_endofpacket_o), 32'(idx == exp_q.size() - 1));
        idx++;
        if (response_endofpacket_o || idx > exp_q.size()) done = 1'b1;
      end
      held  = response_valid_o && !rr;
      pdata = response_data_o;
      psop  = response_startofpacket_o;
      peop  = response_endofpacket_o;
      tick();
      n++;
    end

    if (aborted) begin
      reset = 1'b0;
      tick();
      check_eq({tag, "_rst_valid"}, 32'(response_valid_o), 32'd0);
      check_eq({tag, "_rst_ready"}, 32'(command_ready_o), 32'd0);
      check_eq({tag, "_rst_data"}, response_data_o, 32'd0);
      check_eq({tag, "_rst_sop_eop"}, {30'd0, response_startofpacket_o, response_endofpacket_o}, 32'd0);
      reset = 1'b1;
      tick();
      check_eq({tag, "_rel_ready"}, 32'(command_ready_o), 32'd1);
      vleak = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (response_valid_o) vleak = 1'b1;
        tick();
      end
      check_eq({tag, "_no_stale_rsp"}, 32'(vleak), 32'd0);
      response_ready_i = 1'b0;
    end else begin
      response_ready_i = 1'b0;
      check_eq({tag, "_done"}, 32'(done), 32'd1);
      check_eq({tag, "_latency"}, 32'(lat), 32'(LAT));
      check_eq({tag, "_count"}, 32'(idx), 32'(exp_q.size()));
      check_eq({tag, "_no_overlap"}, 32'(leak), 32'd0);
      check_eq({tag, "_idle_ready"}, 32'(command_ready_o), 32'd1);
      check_eq({tag, "_idle_valid"}, 32'(response_valid_o), 32'd0);
    end
  endtask

  initial begin
    int kind, sel, rmode, nch;
    logic [7:0]  op;
    logic [15:0] mask;
    shuffle_samples();
    repeat (3) tick();
    check_eq("rst_cmd_ready", 32'(command_ready_o), 32'd0);
    check_eq("rst_rsp_valid", 32'(response_valid_o), 32'd0);
    check_eq("rst_rsp_data", response_data_o, 32'd0);
    check_eq("rst_rsp_sop", 32'(response_startofpacket_o), 32'd0);
    check_eq("rst_rsp_eop", 32'(response_endofpacket_o), 32'd0);
    reset = 1'b1;
    tick();
    check_eq("rst_release_ready", 32'(command_ready_o), 32'd1);

    shuffle_samples();
    voltage_sample_i[0] = 32'h0001_0000;
    voltage_sample_i[2] = 32'h0000_C000;
    run_txn("volt_basic", 0, OP_V, 16'h0005, 0, 1'b1, -1);
    check_eq("volt_basic_len", 32'(got_q.size()), 32'd3);
    if (got_q.size() == 3) begin
      check_eq("volt_basic_hdr", got_q[0], 32'h0000_0218);
      check_eq("volt_basic_d0", got_q[1], 32'h0001_0000);
      check_eq("volt_basic_d1", got_q[2], 32'h0000_C000);
    end

    run_txn("bad_op", 0, 8'h55, 16'h0001, 0, 1'b0, -1);
    check_eq("bad_op_len", 32'(got_q.size()), 32'd1);
    if (got_q.size() == 1) check_eq("bad_op_hdr", got_q[0], 32'h0001_0055);

    run_txn("temp_range", 0, OP_T, 16'h0020, 2, 1'b0, -1);
    check_eq("temp_range_len", 32'(got_q.size()), 32'd1);
    if (got_q.size() == 1) check_eq("temp_range_hdr", got_q[0], 32'h0002_0019);

    run_txn("temp_toggle", 0, OP_T, 16'h001F, 1, 1'b0, -1);
    check_eq("temp_toggle_len", 32'(got_q.size()), 32'd6);

    run_txn("drain", 2, OP_V, 16'h0003, 0, 1'b0, -1);
    check_eq("drain_len", 32'(got_q.size()), 32'd1);
    if (got_q.size() == 1) check_eq("drain_hdr", got_q[0], 32'h0003_0018);
    run_txn("post_drain", 0, OP_V, 16'h0102, 2, 1'b0, -1);

    run_txn("mask0", 0, OP_V, 16'h0000, 0, 1'b0, -1);
    check_eq("mask0_len", 32'(got_q.size()), 32'd1);
    if (got_q.size() == 1) check_eq("mask0_hdr", got_q[0], 32'h0000_0018);

    run_txn("single", 1, OP_T, 16'h0000, 0, 1'b0, -1);
    run_txn("junk", 3, OP_T, 16'h0011, 2, 1'b0, -1);
    run_txn("volt_full", 0, OP_V, 16'h01FF, 2, 1'b0, -1);
    run_txn("volt_range", 0, OP_V, 16'h0200, 0, 1'b0, -1);

    run_txn("abort", 0, OP_V, 16'h0007, 0, 1'b0, 2);
    run_txn("after_abort", 0, OP_V, 16'h0001, 0, 1'b0, -1);
    check_eq("after_abort_len", 32'(got_q.size()), 32'd2);

    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(9);
      kind = (sel == 6) ? 1 : (sel == 7) ? 2 : (sel == 8) ? 3 : 0;
      sel = $urandom_range(5);
      op = (sel < 3) ? OP_V : (sel < 5) ? OP_T : 8'($urandom());
      nch = (op == OP_V) ? NV : NT;
      if ($urandom_range(3) == 0) mask = 16'($urandom());
      else mask = 16'($urandom() & ((32'd1 << nch) - 32'd1));
      rmode = $urandom_range(2);
      run_txn("rand", kind, op, mask, rmode, 1'b0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
